// File: rtl/histogram_esitleme_lut_if.sv
// rtl/histogram_esitleme_lut_if.sv - stream and status bundle for the equalisation LUT stage
//
// Purpose: groups the CDF input stream, the pixel input/output streams and the
//          status flags of histogram_esitleme_lut into one interface.
// Signals (named from the LUT stage's point of view):
//   cdf_gecerli_i    CDF beat valid (bins 0..255 in order, gaps allowed)
//   cdf_i            cumulative count of the current bin
//   cdf_min_i        smallest non-zero CDF, taken on the bin-0 beat
//   pixel_gecerli_i  input pixel valid
//   pixel_i          input pixel
//   pixel_hazir_o    ready for pixels (only while the LUT is in use)
//   pixel_gecerli_o  mapped pixel valid
//   pixel_o          mapped pixel
//   lut_hazir_o      LUT complete and in use
//   mesgul_o         capturing CDF or building the LUT
// Modports: master drives the streams (upstream/bench), slave is the LUT stage.

interface histogram_esitleme_lut_if #(
   parameter int PIXEL_BIT = 8,
   parameter int CDF_BIT   = 17
);
   logic                 cdf_gecerli_i;
   logic [CDF_BIT-1:0]   cdf_i;
   logic [CDF_BIT-1:0]   cdf_min_i;
   logic                 pixel_gecerli_i;
   logic [PIXEL_BIT-1:0] pixel_i;
   logic                 pixel_hazir_o;
   logic                 pixel_gecerli_o;
   logic [PIXEL_BIT-1:0] pixel_o;
   logic                 lut_hazir_o;
   logic                 mesgul_o;

   modport master (
      output cdf_gecerli_i, cdf_i, cdf_min_i, pixel_gecerli_i, pixel_i,
      input  pixel_hazir_o, pixel_gecerli_o, pixel_o, lut_hazir_o, mesgul_o
   );

   modport slave (
      input  cdf_gecerli_i, cdf_i, cdf_min_i, pixel_gecerli_i, pixel_i,
      output pixel_hazir_o, pixel_gecerli_o, pixel_o, lut_hazir_o, mesgul_o
   );
endinterface

// File: rtl/histogram_esitleme_lut.sv
// rtl/histogram_esitleme_lut.sv - CDF capture, equalisation LUT build and pixel remap
//
// Purpose: captures a 256-bin CDF stream and cdf_min, builds
//          map[k] = ((cdf[k]-cdf_min)*255) / (PIXEL_SAYISI-cdf_min)
//          with a bit-serial restoring divider (26 cycles per bin), then maps
//          incoming pixels through the LUT with one cycle of latency.
// Ports:
//   clk_i    clock
//   rstn_i   asynchronous active-low reset
//   bus      histogram_esitleme_lut_if.slave (CDF stream, pixel streams, status)
// Parameters:
//   PIXEL_SAYISI  pixels per frame, must be < 2^17
//   PIXEL_BIT     pixel width, LUT depth 2^PIXEL_BIT
// Build option:
//   HE_YUVARLA_EN  defined: round to nearest (num += denom>>1); otherwise truncate.
//                  Cycle counts are the same in both builds.

module histogram_esitleme_lut #(
   parameter int PIXEL_SAYISI = 76800,
   parameter int PIXEL_BIT    = 8
) (
   input  logic clk_i,
   input  logic rstn_i,
   histogram_esitleme_lut_if.slave bus
);
   localparam int CW    = 17;                 // CDF width
   localparam int NB    = 1 << PIXEL_BIT;     // LUT depth
   localparam int NW    = CW + PIXEL_BIT;     // numerator / quotient width
   localparam int CYC_W = $clog2(NW + 1);

   localparam logic [NW-1:0]    OLCEK  = NW'(NB - 1);
   localparam logic [CW-1:0]    N_C    = CW'(PIXEL_SAYISI);
   localparam logic [CYC_W-1:0] SON_AD = CYC_W'(NW);

   typedef enum logic [1:0] {BOS, CDF_AL, HESAPLA, ESLE} durum_t;

   durum_t               durum_q, durum_d;
   logic [PIXEL_BIT-1:0] idx_q, idx_d;
   logic [CYC_W-1:0]     cyc_q, cyc_d;
   logic [CW-1:0]        cdf_min_q, cdf_min_d;
   logic [CW-1:0]        kalan_q, kalan_d;    // divider remainder
   logic [NW-1:0]        bolum_q, bolum_d;    // dividend shifting out, quotient shifting in
   logic                 pgv_q, pgv_d;
   logic [PIXEL_BIT-1:0] pix_q, pix_d;

   logic [CW-1:0]        cdf_ram [NB];
   logic [PIXEL_BIT-1:0] lut_ram [NB];

   logic                 cdf_we;
   logic [PIXEL_BIT-1:0] cdf_waddr;
   logic                 lut_we;
   logic [PIXEL_BIT-1:0] lut_wdata;

   logic [CW-1:0]        payda;
   logic [CW-1:0]        cdf_k;
   logic [CW-1:0]        fark;
   logic [NW-1:0]        pay;
   logic [CW:0]          kay;
   logic                 ge;
   logic [CW-1:0]        kalan_next;
   logic [NW-1:0]        bolum_next;
   logic                 kabul;

   // Datapath for the divider
   always_comb begin
      payda = N_C - cdf_min_q;
      cdf_k = cdf_ram[idx_q];
      fark  = (cdf_k > cdf_min_q) ? (cdf_k - cdf_min_q) : '0;
`ifdef HE_YUVARLA_EN
      pay   = (NW'(fark) * OLCEK) + NW'(payda >> 1);
`else
      pay   = NW'(fark) * OLCEK;
`endif
      // One restoring step: bring down the next dividend bit, subtract if it fits
      kay        = {kalan_q, bolum_q[NW-1]};
      ge         = (kay >= {1'b0, payda});
      kalan_next = ge ? CW'(kay - {1'b0, payda}) : CW'(kay);
      bolum_next = {bolum_q[NW-2:0], ge};
      // Degenerate single-level frame maps to identity; large quotients saturate
      if (payda == '0)
         lut_wdata = idx_q;
      else if (|bolum_next[NW-1:PIXEL_BIT])
         lut_wdata = '1;
      else
         lut_wdata = bolum_next[PIXEL_BIT-1:0];
   end

   assign kabul = (durum_q == ESLE) && bus.pixel_gecerli_i;

   // Next-state and control
   always_comb begin
      durum_d   = durum_q;
      idx_d     = idx_q;
      cyc_d     = cyc_q;
      cdf_min_d = cdf_min_q;
      kalan_d   = kalan_q;
      bolum_d   = bolum_q;
      pgv_d     = 1'b0;
      pix_d     = pix_q;
      cdf_we    = 1'b0;
      cdf_waddr = idx_q;
      lut_we    = 1'b0;

      case (durum_q)
         BOS: begin
            if (bus.cdf_gecerli_i) begin
               cdf_we    = 1'b1;
               cdf_waddr = '0;
               cdf_min_d = bus.cdf_min_i;
               idx_d     = PIXEL_BIT'(1);
               durum_d   = CDF_AL;
            end
         end
         CDF_AL: begin
            if (bus.cdf_gecerli_i) begin
               cdf_we = 1'b1;
               if (idx_q == '1) begin
                  idx_d   = '0;
                  cyc_d   = '0;
                  durum_d = HESAPLA;
               end else begin
                  idx_d = idx_q + PIXEL_BIT'(1);
               end
            end
         end
         HESAPLA: begin
            if (cyc_q == '0) begin
               kalan_d = '0;
               bolum_d = pay;
               cyc_d   = CYC_W'(1);
            end else begin
               kalan_d = kalan_next;
               bolum_d = bolum_next;
               if (cyc_q == SON_AD) begin
                  lut_we = 1'b1;
                  cyc_d  = '0;
                  idx_d  = idx_q + PIXEL_BIT'(1);
                  if (idx_q == '1)
                     durum_d = ESLE;
               end else begin
                  cyc_d = cyc_q + CYC_W'(1);
               end
            end
         end
         ESLE: begin
            // The LUT is not written until HESAPLA, so a pixel accepted
            // alongside a new-frame beat still sees the old mapping.
            if (kabul) begin
               pgv_d = 1'b1;
               pix_d = lut_ram[bus.pixel_i];
            end
            if (bus.cdf_gecerli_i) begin
               cdf_we    = 1'b1;
               cdf_waddr = '0;
               cdf_min_d = bus.cdf_min_i;
               idx_d     = PIXEL_BIT'(1);
               durum_d   = CDF_AL;
            end
         end
         default: durum_d = BOS;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         durum_q   <= BOS;
         idx_q     <= '0;
         cyc_q     <= '0;
         cdf_min_q <= '0;
         kalan_q   <= '0;
         bolum_q   <= '0;
         pgv_q     <= 1'b0;
         pix_q     <= '0;
      end else begin
         durum_q   <= durum_d;
         idx_q     <= idx_d;
         cyc_q     <= cyc_d;
         cdf_min_q <= cdf_min_d;
         kalan_q   <= kalan_d;
         bolum_q   <= bolum_d;
         pgv_q     <= pgv_d;
         pix_q     <= pix_d;
      end
   end

   // Storage without reset; contents are always rebuilt before use
   always_ff @(posedge clk_i) begin
      if (cdf_we)
         cdf_ram[cdf_waddr] <= bus.cdf_i;
      if (lut_we)
         lut_ram[idx_q] <= lut_wdata;
   end

   assign bus.pixel_hazir_o   = (durum_q == ESLE);
   assign bus.lut_hazir_o     = (durum_q == ESLE);
   assign bus.mesgul_o        = (durum_q == CDF_AL) || (durum_q == HESAPLA);
   assign bus.pixel_gecerli_o = pgv_q;
   assign bus.pixel_o         = pix_q;
endmodule
